// File: rtl/sdram_pkg.sv
// ----------------------------------------------------------------------------
// sdram_pkg - shared widths, byteenable constant and burst-reader FSM encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sdram_pkg;

    localparam int         SDRAM_ADDR_W     = 26;
    localparam int         SDRAM_DATA_W     = 16;
    localparam logic [1:0] SDRAM_BYTEENABLE = 2'b11;

    typedef logic [1:0] rd_state_t;

    localparam rd_state_t ST_IDLE  = 2'd0;
    localparam rd_state_t ST_ISSUE = 2'd1;
    localparam rd_state_t ST_DRAIN = 2'd2;
    localparam rd_state_t ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo - show-ahead synchronous FIFO with occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    // Head reads as zero while empty so the output is deterministic after reset.
    assign head   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(DEPTH)) && !do_pop));

endmodule

`default_nettype wire

// File: rtl/sdram_burst_reader.sv
// ----------------------------------------------------------------------------
// sdram_burst_reader - credit-limited Avalon-MM burst reader feeding a stream
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sdram_burst_reader
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = SDRAM_ADDR_W,
    parameter int DATA_W     = SDRAM_DATA_W,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_chipselect,
    output logic [1:0]        m_byteenable,
    input  logic              m_waitrequest,
    input  logic              m_readdatavalid,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = CNT_W + 1;

    rd_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic [CNT_W-1:0]  pending;
    logic [CNT_W-1:0]  pending_next;
    logic [CNT_W-1:0]  fifo_count;
    logic [CRD_W-1:0]  credits;
    logic              fifo_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic              can_raise;
    logic              can_continue;

    assign accept = m_read && !m_waitrequest;
    // Data with nothing outstanding is a leftover from before a reset.
    assign push   = m_readdatavalid && (pending != '0);
    assign pop    = out_valid && out_ready;

    // Free FIFO slots not yet promised to in-flight reads; a same-cycle pop is
    // ignored, which only delays the next request by a cycle.
    assign credits      = CRD_W'(FIFO_DEPTH) - CRD_W'(fifo_count) - CRD_W'(pending);
    assign can_raise    = (credits != '0);
    assign can_continue = (credits > CRD_W'(1));

    always_comb begin
        pending_next = pending;
        if (accept && !push) begin
            pending_next = pending + CNT_W'(1);
        end else if (!accept && push) begin
            pending_next = pending - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            pending   <= '0;
            m_read    <= 1'b0;
        end else begin
            pending <= pending_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state     <= ST_ISSUE;
                            addr      <= base_addr;
                            remaining <= length;
                            m_read    <= can_raise;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state  <= ST_DRAIN;
                            m_read <= 1'b0;
                        end else begin
                            m_read <= can_continue;
                        end
                    end else if (!m_read) begin
                        m_read <= can_raise;
                    end
                end
                ST_DRAIN: begin
                    if (pending_next == '0) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign m_address    = addr;
    assign m_chipselect = m_read;
    assign m_byteenable = SDRAM_BYTEENABLE;
    assign out_valid    = !fifo_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (m_readdata),
        .pop       (pop),
        .head      (out_data),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_sdram_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_sdram_burst_reader - randomized bench with a queue-based transfer model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sdram_burst_reader;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 12;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy, done, m_read, m_chipselect, out_valid;
    logic [ADDR_W-1:0] m_address;
    logic [1:0]        m_byteenable;
    logic              m_waitrequest = 1'b0;
    logic              m_readdatavalid = 1'b0;
    logic [DATA_W-1:0] m_readdata = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;

    always #5 clk = ~clk;

    sdram_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .m_address(m_address), .m_read(m_read),
        .m_chipselect(m_chipselect), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
        .m_readdata(m_readdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Model: words owed to the stream, reads in flight, and the SDRAM slave.
    logic [DATA_W-1:0] fifo_q[$];
    logic [ADDR_W-1:0] ret_addr_q[$];
    logic [ADDR_W-1:0] slv_addr_q[$];
    int                slv_due_q[$];
    logic [ADDR_W-1:0] acc_log[$];
    int                acc_cyc[$];
    logic [DATA_W-1:0] pop_log[$];
    bit                m_busy, m_done, prev_pend;
    logic [ADDR_W-1:0] prev_addr, xfer_next;
    int                xfer_len, xfer_acc, xfer_ret;
    int                cyc, n_checks, n_fail, done_cnt;
    int                lat_min = 2, lat_max = 2, wr_pct = 0, rdy_pct = 100;
    int                stall_nth = -1, stall_left = 0;
    bit                start_req, rst_req = 1'b1;
    logic [ADDR_W-1:0] req_base;
    logic [LEN_W-1:0]  req_len;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ {6'h0, a[25:16]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare DUT against the model, drive next inputs, advance the model.
    task automatic step();
        bit acc, rdv, pop, done_now;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("out_valid", 32'(out_valid), 32'(fifo_q.size() != 0));
            if (fifo_q.size() != 0) chk("out_data", 32'(out_data), 32'(fifo_q[0]));
            chk("chipselect", 32'(m_chipselect), 32'(m_read));
            chk("byteenable", 32'(m_byteenable), 32'h3);
            if (prev_pend) begin
                chk("read_held", 32'(m_read), 32'h1);
                chk("addr_held", 32'(m_address), 32'(prev_addr));
            end
            if (m_read) begin
                chk("read_has_credit", 32'((ret_addr_q.size() + fifo_q.size()) < DEPTH), 32'h1);
                chk("read_within_len", 32'(m_busy && (xfer_acc < xfer_len)), 32'h1);
            end
            if (done) done_cnt++;
        end
        rst = rst_req;
        start = start_req && !rst_req;
        base_addr = req_base;
        length = req_len;
        start_req = 1'b0;
        if (m_read && stall_left > 0 && xfer_acc == stall_nth) begin
            m_waitrequest = 1'b1;
            stall_left--;
        end else begin
            m_waitrequest = ($urandom_range(99) < wr_pct);
        end
        out_ready = ($urandom_range(99) < rdy_pct);
        if (!rst_req && slv_addr_q.size() != 0 && slv_due_q[0] <= cyc) begin
            m_readdatavalid = 1'b1;
            m_readdata = mem_word(slv_addr_q.pop_front());
            void'(slv_due_q.pop_front());
        end else begin
            m_readdatavalid = 1'b0;
            m_readdata = DATA_W'($urandom);
        end
        if (rst_req) begin
            fifo_q.delete();
            ret_addr_q.delete();
            m_busy = 0; m_done = 0; prev_pend = 0;
            xfer_len = 0; xfer_acc = 0; xfer_ret = 0;
            return;
        end
        acc = m_read && !m_waitrequest;
        rdv = m_readdatavalid;
        pop = (fifo_q.size() != 0) && out_ready;
        done_now = m_done;
        m_done = 0;
        if (start && !m_busy) begin
            m_busy = 1;
            xfer_len = int'(length); xfer_acc = 0; xfer_ret = 0; xfer_next = base_addr;
            acc_log.delete(); acc_cyc.delete();
            if (length == 0) m_done = 1;
        end else if (done_now) begin
            m_busy = 0;
        end
        if (pop) pop_log.push_back(fifo_q.pop_front());
        if (rdv && ret_addr_q.size() != 0) begin
            fifo_q.push_back(mem_word(ret_addr_q.pop_front()));
            xfer_ret++;
            if (xfer_ret == xfer_len) m_done = 1;
        end
        if (acc) begin
            chk("accept_addr", 32'(m_address), 32'(xfer_next));
            acc_log.push_back(m_address);
            acc_cyc.push_back(cyc);
            ret_addr_q.push_back(xfer_next);
            slv_addr_q.push_back(m_address);
            slv_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            xfer_next++;
            xfer_acc++;
        end
        prev_pend = m_read && !acc;
        prev_addr = m_address;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        start_req = 1'b1; req_base = b; req_len = l;
    endtask

    task automatic wait_done(input int budget, output int took);
        took = 0;
        do begin step(); took++; end while (done !== 1'b1 && took < budget);
        chk("done_reached", 32'(done), 32'h1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        int save = rdy_pct;
        rdy_pct = 100;
        while ((fifo_q.size() != 0 || slv_addr_q.size() != 0 || m_busy) && n < budget) begin
            step(); n++;
        end
        step();
        chk("drained", 32'(out_valid), 32'h0);
        rdy_pct = save;
    endtask

    task automatic reset_values();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_m_read", 32'(m_read), 32'h0);
        chk("rst_chipselect", 32'(m_chipselect), 32'h0);
        chk("rst_m_address", 32'(m_address), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_byteenable", 32'(m_byteenable), 32'h3);
    endtask

    initial begin
        int took, n;
        logic [LEN_W-1:0] rl;
        // Reset
        rst_req = 1'b1;
        repeat (2) step();
        reset_values();
        rst_req = 1'b0;
        step();

        // Basic: 4 words, latency 2, no stalls
        done_cnt = 0; pop_log.delete();
        do_start(26'h100, 12'd4);
        wait_done(60, took);
        chk("basic_count", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
            chk("basic_addr", 32'(acc_log[i]), 32'h100 + 32'(i));
            chk("basic_b2b", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
        end
        drain(40);
        chk("basic_done_pulses", 32'(done_cnt), 32'd1);
        chk("basic_first_word", 32'(pop_log.size() > 0 ? pop_log[0] : 16'h0), 32'h5B3C);

        // Stall on the second request for 3 cycles
        stall_nth = 1; stall_left = 3;
        do_start(26'h100, 12'd4);
        wait_done(60, took);
        chk("stall_count", 32'(acc_log.size()), 32'd4);
        if (acc_log.size() == 4) begin
            chk("stall_addr1", 32'(acc_log[1]), 32'h101);
            chk("stall_addr2", 32'(acc_log[2]), 32'h102);
            chk("stall_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        end
        stall_nth = -1;
        drain(40);

        // Backpressure: 40 words into a 16-deep FIFO with the sink stalled
        pop_log.delete(); rdy_pct = 0;
        do_start(26'h2000, 12'd40);
        repeat (60) step();
        chk("bp_issued", 32'(xfer_acc), 32'd16);
        chk("bp_read_low", 32'(m_read), 32'h0);
        rdy_pct = 100;
        wait_done(300, took);
        chk("bp_issued_all", 32'(xfer_acc), 32'd40);
        drain(60);
        chk("bp_delivered", 32'(pop_log.size()), 32'd40);

        // Zero length
        do_start(26'h55, 12'd0);
        wait_done(10, took);
        chk("zero_len_latency", 32'(took), 32'd2);
        chk("zero_len_reads", 32'(acc_log.size()), 32'd0);
        step();

        // Address wrap
        pop_log.delete(); lat_min = 1; lat_max = 1;
        do_start(26'h3FFFFFE, 12'd3);
        wait_done(40, took);
        chk("wrap_count", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            chk("wrap_a0", 32'(acc_log[0]), 32'h3FFFFFE);
            chk("wrap_a1", 32'(acc_log[1]), 32'h3FFFFFF);
            chk("wrap_a2", 32'(acc_log[2]), 32'h0);
        end
        drain(40);
        chk("wrap_word1", 32'(pop_log.size() > 1 ? pop_log[1] : 16'h0), 32'hA63C);

        // Start while busy is ignored
        lat_min = 3; lat_max = 3;
        do_start(26'h500, 12'd6);
        repeat (3) step();
        do_start(26'h900, 12'd2);
        wait_done(60, took);
        chk("busy_start_count", 32'(acc_log.size()), 32'd6);
        if (acc_log.size() == 6) chk("busy_start_last", 32'(acc_log[5]), 32'h505);
        drain(40);

        // Randomized transfers with stalls, backpressure and varying latency
        lat_min = 1; lat_max = 4; wr_pct = 25; rdy_pct = 70;
        for (int t = 0; t < 10; t++) begin
            rl = LEN_W'($urandom_range(40, 0));
            do_start(ADDR_W'($urandom), rl);
            step();
            if (rl >= 8 && m_busy && !m_done) do_start(ADDR_W'($urandom), LEN_W'(5));
            wait_done(2000, took);
        end
        wr_pct = 0;
        drain(200);

        // Reset with three reads outstanding; late data must be discarded
        lat_min = 6; lat_max = 6; rdy_pct = 100;
        do_start(26'h40, 12'd8);
        n = 0;
        while (ret_addr_q.size() < 3 && n < 20) begin step(); n++; end
        chk("outstanding_before_reset", 32'(ret_addr_q.size()), 32'd3);
        rst_req = 1'b1;
        repeat (2) step();
        reset_values();
        rst_req = 1'b0;
        n = 0;
        while (slv_addr_q.size() != 0 && n < 30) begin step(); n++; end
        step(); step();
        chk("stale_discarded", 32'(out_valid), 32'h0);
        pop_log.delete(); lat_min = 2; lat_max = 2;
        do_start(26'h77, 12'd5);
        wait_done(60, took);
        drain(40);
        chk("post_reset_words", 32'(pop_log.size()), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/sdram_burst_reader.md
# sdram_burst_reader

Avalon-MM read initiator that fetches a contiguous run of 16-bit words from SDRAM and presents them as a valid/ready stream. It drives the slave side of the SDRAM pass-through bridge (address, read, chipselect, byteenable) and consumes the returned data. Pipelined reads are tracked with an outstanding-read counter and buffered in an internal FIFO, so downstream stalls never overflow the buffer. Typical client: display/line fetch logic that needs one line of pixels per request.

## Interface
- ADDR_W, 26, word address width toward the SDRAM bridge
- DATA_W, 16, data word width
- LEN_W, 12, width of the transfer length (words)
- FIFO_DEPTH, 16, output FIFO depth in words (power of two, ≥2)

- clk  in  1  system clock
- rst  in  1  reset; one clock; asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, captured on accepted start
- length  in  LEN_W  word count, captured on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse: all requested words written into FIFO
- m_address  out  ADDR_W  read address
- m_read  out  1  read request, active-high
- m_chipselect  out  1  equals m_read
- m_byteenable  out  2  constant 2'b11
- m_waitrequest  in  1  bridge stall; request accepted when m_read && !m_waitrequest
- m_readdatavalid  in  1  read data valid
- m_readdata  in  DATA_W  read data
- out_data  out  DATA_W  FIFO head word
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accept; pop on out_valid && out_ready

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1, length≠0 → latch base_addr/length into addr/remaining, → ISSUE. start=1, length=0 → DONE (no reads). start while not IDLE ignored.
- ISSUE: m_read raised only when credits ≥1, credits = FIFO_DEPTH − fifo_count − pending. Once raised, m_read and m_address held stable until accepted (never withdrawn). On accept: addr+1, remaining−1, pending+1. Accept of last word → DRAIN.
- DRAIN: m_read low; wait for pending=0 → DONE.
- DONE: done=1 for one cycle, → IDLE.
- m_readdatavalid: push m_readdata into FIFO, pending−1. Same-cycle accept and readdatavalid: pending unchanged. Arriving with pending=0 (e.g., stale after reset): discarded.
- Address arithmetic: ADDR_W-bit unsigned, wraps from all-ones to 0 silently.
- FIFO: show-ahead; push and pop independent, simultaneous push+pop keeps count. Credit rule guarantees no push when full; push-on-full is an assertion failure, not handled.
- FIFO contents persist across done; next transfer appends behind unread words.

## Timing
- Reset values: busy=0, done=0, m_read=0, m_chipselect=0, m_address=0, out_valid=0, out_data=0; state IDLE, pending=0, FIFO empty. m_byteenable=2'b11 always.
- Start accepted at edge N → busy=1 and m_read may assert at N+1 (registered outputs).
- Back-to-back: with waitrequest=0 and credits available, one accept per cycle.
- Readdatavalid at edge N → out_valid=1 at N+1 (FIFO empty case).
- Final readdatavalid at N → done pulse at N+1 (state DONE), busy=0 at N+2.
- length=0: done at start+1 cycle, busy high for exactly that one cycle.
- Reset mid-transfer: all state and FIFO cleared immediately; outstanding data returning later discarded.

## Structure
- Shared package sdram_pkg: ADDR_W/DATA_W defaults, byteenable constant, state enum typedef rd_state_t.
- Sub-module sync_fifo (parameterised depth/width, show-ahead, count output) instantiated once; FSM, address/remaining/pending counters in top.

## Test plan
- Basic: base=0x100, length=4, waitrequest=0, 2-cycle read latency, out_ready=1 → addresses 0x100..0x103 on consecutive cycles, 4 words streamed in order, one done pulse.
- Stall: waitrequest high 3 cycles on 2nd request → m_read/m_address=0x101 held stable, no duplicate or skipped address.
- Backpressure: length=40, FIFO_DEPTH=16, out_ready=0 → issued reads stop at 16, m_read low; raise out_ready → remaining 24 issued, all 40 words delivered in order.
- Edge cases: length=0 → done pulse one cycle after start, no m_read; base=0x3FFFFFE, length=3 → addresses 0x3FFFFFE, 0x3FFFFFF, 0x0000000.
- Start while busy → ignored, transfer unchanged.
- Reset with 3 reads outstanding → outputs at reset values; late readdatavalid pulses produce no out_valid; subsequent start runs normally.
